pwm_audio_stream: RTL and testbench

Streaming PWM audio player, next generation of the single-channel PWM sample generator.
- Accepts samples over a valid/ready stream into an internal FIFO.
- Pops one sample per programmable sample tick and scales it to a parametrised PWM period.
- Adds priming, underrun handling with a counter, volume attenuation, and amplifier shutdown control.
- Sits between the music data fetch logic (memory/AXI side) and the board audio pins.

---
 rtl/pwm_audio_stream.sv | 88 ++++++++
 tb/tb_pwm_audio_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_stream.sv
// pwm_audio_stream: FIFO-fed PWM audio player with priming, underrun count, volume and amp control.
// Define AUDIO_SIGNED_EN for two's-complement s_data; the default is offset binary.
module pwm_audio_stream #(
    parameter int SAMPLE_W    = 8,
    parameter int PWM_PERIOD  = 2268,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [31:0]                 divisor,
    input  logic [2:0]                  vol_shift,
    input  logic [SAMPLE_W-1:0]         s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        pwm_out,
    output logic                        aud_sd,
    output logic                        sample_tick,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 underrun_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PWM_PERIOD);
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

    state_t                     state, state_n;
    logic [SAMPLE_W-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [SAMPLE_W-1:0]        cur_sample, rd_data;
    logic signed [SAMPLE_W-1:0] s_in, s_att;
    logic [CW-1:0]              duty, pwm_cnt;
    logic [31:0]                tick_cnt, d_eff;
    logic                       push, pop, empty;

    always_comb begin
        empty       = fifo_level == '0;
        s_ready     = fifo_level != LW'(FIFO_DEPTH);
        push        = s_valid && s_ready;
        d_eff       = divisor < 32'd2 ? 32'd2 : divisor;
        // >= rather than == so a shrinking divisor wraps at once instead of running off
        sample_tick = state == PLAY && tick_cnt >= d_eff - 32'd1;
        pop         = sample_tick && !empty;
        aud_sd      = state != IDLE;
        rd_data     = mem[rd_ptr];
`ifdef AUDIO_SIGNED_EN
        s_in        = rd_data;
`else
        s_in        = rd_data ^ MID;
`endif
        s_att       = s_in >>> vol_shift;
        state_n     = !enable ? IDLE :
                      state == IDLE ? PRIME :
                      (state == PRIME && fifo_level >= LW'(PRIME_LEVEL)) ? PLAY : state;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= s_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            cur_sample   <= MID;
            duty         <= '0;
            pwm_cnt      <= '0;
            tick_cnt     <= '0;
            pwm_out      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            tick_cnt   <= (state == PLAY && !sample_tick) ? tick_cnt + 32'd1 : '0;
            pwm_cnt    <= (state != PLAY || pwm_cnt == CW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
            if (sample_tick) cur_sample <= empty ? MID : $unsigned(s_att) ^ MID;
            duty       <= CW'((32'(cur_sample) * 32'(PWM_PERIOD)) >> SAMPLE_W);
            pwm_out    <= state == PLAY && duty > pwm_cnt;
            if (sample_tick && empty && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pwm_audio_stream.sv
// tb_pwm_audio_stream: directed checks of priming, duty, volume, FIFO, underrun, divisor and reset.
module tb_pwm_audio_stream;
    logic        clk = 1'b0;
    logic        reset, enable, s_valid;
    logic [31:0] divisor;
    logic [2:0]  vol_shift;
    logic [7:0]  s_data;
    logic        s_ready, pwm_out, aud_sd, sample_tick;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;
    int          n_cmp = 0, n_err = 0;

`ifdef AUDIO_SIGNED_EN
    localparam int E00 = 8, E80 = 0, EFF = 7, EFF_V1 = 7, EFF_V7 = 7, E7F = 15;
`else
    localparam int E00 = 0, E80 = 8, EFF = 15, EFF_V1 = 11, EFF_V7 = 8, E7F = 7;
`endif

    pwm_audio_stream #(.SAMPLE_W(8), .PWM_PERIOD(16), .FIFO_DEPTH(16), .PRIME_LEVEL(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .divisor(divisor), .vol_shift(vol_shift),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .pwm_out(pwm_out),
        .aud_sd(aud_sd), .sample_tick(sample_tick), .fifo_level(fifo_level),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < budget);
        if (!sample_tick) n = -1;
    endtask

    task automatic high_count(output int h);
        repeat (3) step();
        h = 0;
        repeat (16) begin
            h += int'(pwm_out);
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; divisor = 40; vol_shift = 0;
        step(); step();
        reset = 1'b0;
        step();
        n_cmp++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        n_cmp++; if (aud_sd !== 1'b0) begin n_err++; $display("FAIL reset_aud_sd: got %b want 0", aud_sd); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (underrun_cnt !== 16'd0) begin n_err++; $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_priming();
        int ticks, highs, n;
        logic [7:0] smp [8] = '{8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h80};
        enable = 1'b1;
        step();
        n_cmp++; if (aud_sd !== 1'b1) begin n_err++; $display("FAIL prime_aud_sd: got %b want 1", aud_sd); end
        for (int i = 0; i < 7; i++) push(smp[i]);
        n_cmp++; if (fifo_level !== 5'd7) begin n_err++; $display("FAIL prime_level7: got %0d want 7", fifo_level); end
        ticks = 0; highs = 0;
        repeat (50) begin
            ticks += int'(sample_tick);
            highs += int'(pwm_out);
            step();
        end
        n_cmp++; if (ticks !== 0) begin n_err++; $display("FAIL prime_no_tick: got %0d ticks want 0", ticks); end
        n_cmp++; if (highs !== 0) begin n_err++; $display("FAIL prime_pwm_low: got %0d high want 0", highs); end
        push(smp[7]);
        wait_tick(100, n);
        n_cmp++; if (n !== 40) begin n_err++; $display("FAIL prime_first_tick: got %0d clk want 40", n); end
    endtask

    task automatic test_duty();
        int h, n;
        high_count(h);
        n_cmp++; if (h !== E00) begin n_err++; $display("FAIL duty_00: got %0d want %0d", h, E00); end
        n_cmp++; if (fifo_level !== 5'd7) begin n_err++; $display("FAIL duty_pop_level: got %0d want 7", fifo_level); end
        wait_tick(100, n);
        high_count(h);
        n_cmp++; if (h !== E80) begin n_err++; $display("FAIL duty_80: got %0d want %0d", h, E80); end
        wait_tick(100, n);
        high_count(h);
        n_cmp++; if (h !== EFF) begin n_err++; $display("FAIL duty_ff: got %0d want %0d", h, EFF); end
    endtask

    task automatic test_volume();
        int h, n;
        vol_shift = 3'd1;
        wait_tick(100, n);
        high_count(h);
        n_cmp++; if (h !== EFF_V1) begin n_err++; $display("FAIL vol_shift1: got %0d want %0d", h, EFF_V1); end
        vol_shift = 3'd7;
        wait_tick(100, n);
        high_count(h);
        n_cmp++; if (h !== EFF_V7) begin n_err++; $display("FAIL vol_shift7: got %0d want %0d", h, EFF_V7); end
        vol_shift = 3'd0;
        wait_tick(100, n);
        high_count(h);
        n_cmp++; if (h !== E7F) begin n_err++; $display("FAIL duty_7f: got %0d want %0d", h, E7F); end
    endtask

    task automatic test_push_pop();
        int n;
        wait_tick(100, n);
        n_cmp++; if (fifo_level !== 5'd2) begin n_err++; $display("FAIL pp_level_before: got %0d want 2", fifo_level); end
        push(8'hFF);
        n_cmp++; if (fifo_level !== 5'd2) begin n_err++; $display("FAIL pp_level_after: got %0d want 2", fifo_level); end
    endtask

    task automatic test_underrun();
        int h, n;
        wait_tick(100, n);
        wait_tick(100, n);
        high_count(h);
        n_cmp++; if (h !== EFF) begin n_err++; $display("FAIL ur_last_sample: got %0d want %0d", h, EFF); end
        repeat (3) wait_tick(100, n);
        step();
        n_cmp++; if (underrun_cnt !== 16'd3) begin n_err++; $display("FAIL ur_count: got %0d want 3", underrun_cnt); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL ur_level: got %0d want 0", fifo_level); end
        step(); step();
        h = 0;
        repeat (16) begin
            h += int'(pwm_out);
            step();
        end
        n_cmp++; if (h !== 8) begin n_err++; $display("FAIL ur_midscale: got %0d want 8", h); end
        push(8'h00);
        wait_tick(100, n);
        n_cmp++; if (n <= 0) begin n_err++; $display("FAIL ur_resume_tick: got %0d want tick", n); end
        high_count(h);
        n_cmp++; if (h !== E00) begin n_err++; $display("FAIL ur_resume_duty: got %0d want %0d", h, E00); end
        n_cmp++; if (underrun_cnt !== 16'd3) begin n_err++; $display("FAIL ur_count_hold: got %0d want 3", underrun_cnt); end
    endtask

    task automatic test_reset_mid_play();
        int n;
        push(8'hFF);
        push(8'hFF);
        wait_tick(100, n);
        repeat (3) step();
        n = 0;
        while (!pwm_out && n < 20) begin step(); n++; end
        n_cmp++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_pwm: got %b want 1", pwm_out); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL mid_pwm: got %b want 0", pwm_out); end
        n_cmp++; if (aud_sd !== 1'b0) begin n_err++; $display("FAIL mid_aud_sd: got %b want 0", aud_sd); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
        n_cmp++; if (underrun_cnt !== 16'd0) begin n_err++; $display("FAIL mid_underrun: got %0d want 0", underrun_cnt); end
        enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_backpressure();
        int acc, n;
        s_data = 8'h80; s_valid = 1'b1; acc = 0;
        repeat (20) begin
            acc += int'(s_ready);
            step();
        end
        n_cmp++; if (acc !== 16) begin n_err++; $display("FAIL bp_accepted: got %0d want 16", acc); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", s_ready); end
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL bp_level: got %0d want 16", fifo_level); end
        enable = 1'b1;
        wait_tick(100, n);
        n_cmp++; if (n !== 41) begin n_err++; $display("FAIL bp_first_tick: got %0d want 41", n); end
        step();
        n_cmp++; if (fifo_level !== 5'd15) begin n_err++; $display("FAIL bp_pop_level: got %0d want 15", fifo_level); end
        step();
        n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL bp_refill_level: got %0d want 16", fifo_level); end
    endtask

    task automatic test_divisor();
        int n;
        divisor = 1;
        wait_tick(100, n);
        wait_tick(100, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL div1_period: got %0d want 2", n); end
        divisor = 0;
        wait_tick(100, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL div0_period: got %0d want 2", n); end
        divisor = 3;
        wait_tick(100, n);
        wait_tick(100, n);
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL div3_period: got %0d want 3", n); end
        divisor = 40;
        wait_tick(100, n);
        repeat (10) step();
        divisor = 5;
        wait_tick(100, n);
        n_cmp++; if (n !== 5) begin n_err++; $display("FAIL div_shrink_wrap: got %0d want 5", n); end
        s_valid = 1'b0;
        divisor = 40;
    endtask

    initial begin
        test_reset();
        test_priming();
        test_duty();
        test_volume();
        test_push_pop();
        test_underrun();
        test_reset_mid_play();
        test_backpressure();
        test_divisor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
